cpu_sequencer: RTL and testbench

- Owns the 3-bit FSM state register that drives control_unit.state and consumes control_unit.next_state.
- Adds run/pause/single-step debug control, memory wait-state stalling with a timeout fault, and latching of HALT_STATE.
- Gates the control unit's register/memory write enables so that nothing is written during a stall or pause.
- Counts retired instructions.

---
 rtl/cpu_sequencer.sv | 156 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: owns the control-unit FSM state register and adds
// run/pause/single-step debug control, memory wait-state stalling with a
// timeout fault, HALT latching, write-enable gating and an instruction
// retirement counter.
// Ports: clk, reset (sync, active-high), next_state[2:0], we_in[6:0],
//   mem_ready, run_req, pause_req, step_req -> state[2:0], we_out[6:0],
//   advance, paused, halted, fault, instr_count[CNT_W-1:0],
//   cycle_count[31:0].
// Optional macro SEQ_CYCLE_COUNT_EN enables the active-cycle counter;
// without it cycle_count is tied to zero.
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16,
  parameter int RESET_RUN   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       next_state,
  input  logic [6:0]       we_in,
  input  logic             mem_ready,
  input  logic             run_req,
  input  logic             pause_req,
  input  logic             step_req,
  output logic [2:0]       state,
  output logic [6:0]       we_out,
  output logic             advance,
  output logic             paused,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count,
  output logic [31:0]      cycle_count
);

  localparam logic [2:0] FETCH   = 3'b000;
  localparam logic [2:0] MEMORY  = 3'b011;
  localparam logic [2:0] HALT_ST = 3'b101;

  localparam logic [2:0] M_RUN    = 3'd0;
  localparam logic [2:0] M_PAUSED = 3'd1;
  localparam logic [2:0] M_STEP   = 3'd2;
  localparam logic [2:0] M_HALTED = 3'd3;
  localparam logic [2:0] M_FAULT  = 3'd4;

  localparam logic [2:0] M_RESET =
    (RESET_RUN != 0) ? M_RUN : M_PAUSED;
  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  logic [2:0] mode;
  logic       pause_pending;
  logic       step_started;
  logic [7:0] wait_cnt;

  logic active;
  logic mem_phase;
  logic boundary_stop;
  logic stall;
  logic timeout;

  assign active    = (mode == M_RUN) || (mode == M_STEP);
  assign mem_phase = (state == FETCH) || (state == MEMORY);
  assign boundary_stop = (state == FETCH) &&
    (pause_pending || ((mode == M_STEP) && step_started));
  assign advance = active && !boundary_stop &&
    (!mem_phase || mem_ready);

  // A cycle parked at an instruction boundary is not waiting on memory.
  assign stall   = active && mem_phase && !mem_ready && !boundary_stop;
  assign timeout = stall && (wait_cnt == TMO);

  assign we_out = we_in & {7{advance}};
  assign paused = (mode == M_PAUSED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      mode          <= M_RESET;
      pause_pending <= 1'b0;
      step_started  <= 1'b0;
      wait_cnt      <= '0;
      instr_count   <= '0;
      halted        <= 1'b0;
      fault         <= 1'b0;
    end else begin
      if (advance) begin
        state <= next_state;
      end
      if (advance && state != FETCH && next_state == FETCH) begin
        instr_count <= instr_count + CNT_W'(1);
      end
      if (advance) begin
        wait_cnt <= '0;
      end else if (stall) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      // HALTED and FAULT are sticky until reset.
      if (mode != M_HALTED && mode != M_FAULT) begin
        if (state == HALT_ST) begin
          mode   <= M_HALTED;
          halted <= 1'b1;
        end else if (timeout) begin
          mode  <= M_FAULT;
          fault <= 1'b1;
        end else begin
          unique case (1'b1)
            (mode == M_RUN): begin
              if (boundary_stop) begin
                mode          <= M_PAUSED;
                pause_pending <= 1'b0;
              end else if (pause_req) begin
                pause_pending <= 1'b1;
              end
            end
            (mode == M_PAUSED): begin
              if (run_req) begin
                mode <= M_RUN;
              end else if (step_req) begin
                mode         <= M_STEP;
                step_started <= 1'b0;
              end
            end
            (mode == M_STEP): begin
              if (run_req) begin
                mode         <= M_RUN;
                step_started <= 1'b0;
              end else if (boundary_stop) begin
                mode         <= M_PAUSED;
                step_started <= 1'b0;
              end else if (advance) begin
                step_started <= 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

`ifdef SEQ_CYCLE_COUNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
    end else if (active) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycle_count = cyc_q;
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed scenarios plus randomized traffic against a
// behavioural model of the sequencer's rules.
module tb_cpu_sequencer;

  localparam int TO = 4;
  localparam int CW = 16;

  localparam int MR = 0;
  localparam int MP = 1;
  localparam int MS = 2;
  localparam int MH = 3;
  localparam int MF = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    next_state = 3'd0;
  logic [6:0]    we_in = 7'd0;
  logic          mem_ready = 1'b1;
  logic          run_req = 1'b0;
  logic          pause_req = 1'b0;
  logic          step_req = 1'b0;
  logic [2:0]    state;
  logic [6:0]    we_out;
  logic          advance;
  logic          paused;
  logic          halted;
  logic          fault;
  logic [CW-1:0] instr_count;
  logic [31:0]   cycle_count;

  always #5 clk = ~clk;

  cpu_sequencer #(
    .MEM_TIMEOUT(TO),
    .CNT_W(CW),
    .RESET_RUN(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .next_state(next_state),
    .we_in(we_in),
    .mem_ready(mem_ready),
    .run_req(run_req),
    .pause_req(pause_req),
    .step_req(step_req),
    .state(state),
    .we_out(we_out),
    .advance(advance),
    .paused(paused),
    .halted(halted),
    .fault(fault),
    .instr_count(instr_count),
    .cycle_count(cycle_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit          m_valid = 1'b0;
  int          m_state;
  int          m_mode;
  bit          m_pp;
  bit          m_ss;
  int          m_wait;
  bit          m_halted;
  bit          m_fault;
  logic [CW-1:0] m_cnt;
  logic [31:0] m_cyc;

  function automatic bit m_active();
    return (m_mode == MR) || (m_mode == MS);
  endfunction

  function automatic bit m_memph();
    return (m_state == 0) || (m_state == 3);
  endfunction

  function automatic bit m_bstop();
    return (m_state == 0) &&
      (m_pp || (m_mode == MS && m_ss));
  endfunction

  function automatic bit m_adv();
    return m_active() && !m_bstop() &&
      (!m_memph() || mem_ready);
  endfunction

  task automatic m_update();
    int  s;
    bit  adv;
    bit  bs;
    bit  stl;
    bit  tmo;
    if (reset) begin
      m_valid  = 1'b1;
      m_state  = 0;
      m_mode   = MR;
      m_pp     = 1'b0;
      m_ss     = 1'b0;
      m_wait   = 0;
      m_halted = 1'b0;
      m_fault  = 1'b0;
      m_cnt    = '0;
      m_cyc    = '0;
      return;
    end
    s   = m_state;
    adv = m_adv();
    bs  = m_bstop();
    stl = m_active() && m_memph() && !mem_ready && !bs;
    tmo = stl && (m_wait == TO);
    if (m_active()) m_cyc = m_cyc + 1;
    if (adv && s != 0 && next_state == 3'd0) m_cnt = m_cnt + 1'b1;
    if (adv) m_state = int'(next_state);
    if (adv) m_wait = 0;
    else if (stl) m_wait = m_wait + 1;
    if (m_mode == MH || m_mode == MF) return;
    if (s == 5) begin
      m_mode = MH;
      m_halted = 1'b1;
    end else if (tmo) begin
      m_mode = MF;
      m_fault = 1'b1;
    end else if (m_mode == MR) begin
      if (bs) begin
        m_mode = MP;
        m_pp = 1'b0;
      end else if (pause_req) begin
        m_pp = 1'b1;
      end
    end else if (m_mode == MP) begin
      if (run_req) m_mode = MR;
      else if (step_req) begin
        m_mode = MS;
        m_ss = 1'b0;
      end
    end else if (m_mode == MS) begin
      if (run_req) begin
        m_mode = MR;
        m_ss = 1'b0;
      end else if (bs) begin
        m_mode = MP;
        m_ss = 1'b0;
      end else if (adv) begin
        m_ss = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] exp_cyc();
`ifdef SEQ_CYCLE_COUNT_EN
    return m_cyc;
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    #1;
    if (m_valid) begin
      chk("state", 32'(state), 32'(m_state));
      chk("advance", 32'(advance), 32'(m_adv()));
      chk("we_out", 32'(we_out),
          32'(m_adv() ? we_in : 7'd0));
      chk("paused", 32'(paused), 32'(m_mode == MP));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("instr_count", 32'(instr_count), 32'(m_cnt));
      chk("cycle_count", cycle_count, exp_cyc());
    end
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  function automatic logic [2:0] path_ns(int s);
    case (s)
      0: return 3'd1;
      1: return 3'd2;
      2: return 3'd4;
      3: return 3'd4;
      4: return 3'd0;
      default: return 3'd5;
    endcase
  endfunction

  function automatic logic [2:0] rand_ns(int s);
    int r;
    r = int'($urandom_range(99));
    case (s)
      0: return 3'd1;
      1: return (r < 2) ? 3'd5 : 3'd2;
      2: return (r < 40) ? 3'd3 : ((r < 80) ? 3'd4 : 3'd0);
      3: return (r < 60) ? 3'd4 : 3'd0;
      4: return 3'd0;
      default: return 3'd5;
    endcase
  endfunction

  initial begin
    int stuck;
    @(negedge clk);
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt", 32'(instr_count), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_paused", 32'(paused), 32'd0);
    chk("rst_cyc", cycle_count, 32'd0);

    // straight run, no stalls
    for (int i = 0; i < 7; i++) begin
      next_state = path_ns(m_state);
      we_in = 7'($urandom);
      tick();
      if (i == 3) chk("retire1", 32'(instr_count), 32'd1);
    end
`ifdef SEQ_CYCLE_COUNT_EN
    chk("cyc7", cycle_count, 32'd7);
`else
    chk("cyc7", cycle_count, 32'd0);
`endif
    next_state = 3'd0;
    tick();

    // memory wait state in FETCH
    mem_ready = 1'b0;
    next_state = 3'd1;
    we_in = 7'h7f;
    repeat (3) tick();
    chk("wait_state", 32'(state), 32'd0);
    chk("wait_adv", 32'(advance), 32'd0);
    chk("wait_we", 32'(we_out), 32'd0);
    mem_ready = 1'b1;
    tick();
    chk("wait_done", 32'(state), 32'd1);
    chk("wait_fault", 32'(fault), 32'd0);

    // pause during EXECUTE, then single step
    next_state = 3'd2;
    tick();
    pause_req = 1'b1;
    next_state = 3'd4;
    tick();
    pause_req = 1'b0;
    next_state = 3'd0;
    tick();
    next_state = 3'd1;
    tick();
    chk("pause_p", 32'(paused), 32'd1);
    chk("pause_s", 32'(state), 32'd0);
    tick();
    chk("pause_hold", 32'(state), 32'd0);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    repeat (5) begin
      next_state = path_ns(m_state);
      tick();
    end
    chk("step_p", 32'(paused), 32'd1);
    chk("step_s", 32'(state), 32'd0);
    chk("step_cnt", 32'(instr_count), 32'd4);

    // run+step together while paused
    run_req = 1'b1;
    step_req = 1'b1;
    tick();
    run_req = 1'b0;
    step_req = 1'b0;
    chk("rs_run", 32'(paused), 32'd0);

    // run+pause together while running
    run_req = 1'b1;
    pause_req = 1'b1;
    next_state = 3'd1;
    tick();
    run_req = 1'b0;
    pause_req = 1'b0;
    repeat (4) begin
      next_state = path_ns(m_state);
      tick();
    end
    chk("rp_p", 32'(paused), 32'd1);
    chk("rp_cnt", 32'(instr_count), 32'd5);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;

    // memory timeout in MEMORY
    next_state = 3'd1;
    tick();
    next_state = 3'd2;
    tick();
    next_state = 3'd3;
    tick();
    mem_ready = 1'b0;
    next_state = 3'd4;
    repeat (4) tick();
    chk("to_early", 32'(fault), 32'd0);
    tick();
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_state", 32'(state), 32'd3);
    mem_ready = 1'b1;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("to_stuck", 32'(state), 32'd3);
    chk("to_noadv", 32'(advance), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("to_rst_s", 32'(state), 32'd0);
    chk("to_rst_f", 32'(fault), 32'd0);

    // halt from DECODE
    next_state = 3'd1;
    tick();
    next_state = 3'd5;
    tick();
    chk("h_state", 32'(state), 32'd5);
    chk("h_early", 32'(halted), 32'd0);
    tick();
    chk("h_halt", 32'(halted), 32'd1);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    chk("h_hold", 32'(state), 32'd5);
    chk("h_noadv", 32'(advance), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // randomized traffic
    stuck = 0;
    for (int i = 0; i < 4000; i++) begin
      if (m_mode == MH || m_mode == MF) stuck++;
      else stuck = 0;
      reset = ($urandom_range(999) < 3) || (stuck > 8);
      mem_ready = ($urandom_range(3) != 0);
      pause_req = ($urandom_range(99) < 4);
      run_req = ($urandom_range(99) < 5);
      step_req = ($urandom_range(99) < 6);
      next_state = rand_ns(m_state);
      we_in = 7'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
